// File: rtl/rx_frame_reader_if.sv
// Bus bundle for rx_frame_reader: rfq descriptor pop, rxff word pop and the
// downstream valid/ready word stream. master = the reader, slave = its surroundings.
interface rx_frame_reader_if #(
    parameter int LEN_W = 14
);
    logic [LEN_W-1:0] rfq_dout;
    logic             rfq_empty;
    logic             rfq_re;
    logic [35:0]      rxff_dout;
    logic             rxff_empty;
    logic             rxff_re;
    logic [31:0]      rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_last;
    logic [1:0]       rx_lanes;

    modport master (
        input  rfq_dout, rfq_empty, rxff_dout, rxff_empty, rx_ready,
        output rfq_re, rxff_re, rx_data, rx_valid, rx_last, rx_lanes
    );

    modport slave (
        output rfq_dout, rfq_empty, rxff_dout, rxff_empty, rx_ready,
        input  rfq_re, rxff_re, rx_data, rx_valid, rx_last, rx_lanes
    );
endinterface

// File: rtl/rx_frame_reader.sv
// Drains one rfq descriptor and its rxff words per frame, patching the length header.
// Optional macro RX_FRAME_READER_CRC_STRIP_EN truncates output at len+2 bytes and drains the CRC.
module rx_frame_reader #(
    parameter int LEN_W = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    rx_frame_reader_if.master   bus,
    output logic                sync_err,
    output logic [31:0]         frame_count,
    output logic [31:0]         drop_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HEAD  = 2'd1;
    localparam logic [1:0] S_BODY  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      frame_count_q, frame_count_d;
    logic [31:0]      drop_count_q, drop_count_d;

    logic [3:0]  eof;
    logic        any_eof;
    logic        in_frame;
    logic        valid;
    logic        xfer;
    logic        pop_rfq;
    logic        word_last;
    logic        early_eof;
    logic [1:0]  word_lanes;
    logic [15:0] len16;

    // Highest eof lane h leaves h+1 valid bytes; a full word is encoded as 0.
    function automatic logic [1:0] eof_lanes(input logic [3:0] e);
        if (e[3])      return 2'd0;
        else if (e[2]) return 2'd3;
        else if (e[1]) return 2'd2;
        else           return 2'd1;
    endfunction

    assign eof      = {bus.rxff_dout[8], bus.rxff_dout[17], bus.rxff_dout[26], bus.rxff_dout[35]};
    assign any_eof  = |eof;
    assign in_frame = ~reset & ((state_q == S_HEAD) | (state_q == S_BODY));
    assign valid    = in_frame & ~bus.rxff_empty;
    assign xfer     = valid & bus.rx_ready;
    assign pop_rfq  = ~reset & (state_q == S_IDLE) & enable & ~bus.rfq_empty;
    assign len16    = 16'(len_q);

`ifdef RX_FRAME_READER_CRC_STRIP_EN
    logic [LEN_W-1:0] wc_q, wc_d;
    logic [1:0]       lanes_q, lanes_d;
    logic [LEN_W:0]   len_plus2;
    logic [LEN_W-1:0] wc_init;

    assign len_plus2  = {1'b0, bus.rfq_dout} + (LEN_W+1)'(2);
    assign wc_init    = LEN_W'((len_plus2 + (LEN_W+1)'(3)) >> 2);
    assign early_eof  = any_eof & (wc_q != LEN_W'(1));
    assign word_last  = (wc_q == LEN_W'(1)) | any_eof;
    assign word_lanes = early_eof ? eof_lanes(eof) : lanes_q;
`else
    assign early_eof  = 1'b0;
    assign word_last  = any_eof;
    assign word_lanes = eof_lanes(eof);
`endif

    assign bus.rfq_re   = pop_rfq;
    assign bus.rxff_re  = xfer | (~reset & (state_q == S_DRAIN) & ~bus.rxff_empty);
    assign bus.rx_valid = valid;
    assign bus.rx_last  = valid & word_last;
    assign bus.rx_lanes = (valid & word_last) ? word_lanes : 2'd0;
    assign bus.rx_data  = (state_q == S_HEAD)
                        ? {len16, bus.rxff_dout[16:9], bus.rxff_dout[7:0]}
                        : {bus.rxff_dout[34:27], bus.rxff_dout[25:18],
                           bus.rxff_dout[16:9], bus.rxff_dout[7:0]};
    assign sync_err     = xfer & early_eof;
    assign frame_count  = frame_count_q;
    assign drop_count   = drop_count_q;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
`ifdef RX_FRAME_READER_CRC_STRIP_EN
        wc_d          = wc_q;
        lanes_d       = lanes_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop_rfq) begin
                    len_d = bus.rfq_dout;
`ifdef RX_FRAME_READER_CRC_STRIP_EN
                    wc_d    = wc_init;
                    lanes_d = len_plus2[1:0];
`endif
                    if (bus.rfq_dout == '0) begin
                        state_d      = S_DRAIN;
                        drop_count_d = drop_count_q + 32'd1;
                    end else begin
                        state_d = S_HEAD;
                    end
                end
            end
            S_HEAD, S_BODY: begin
                if (xfer) begin
`ifdef RX_FRAME_READER_CRC_STRIP_EN
                    wc_d = wc_q - LEN_W'(1);
`endif
                    if (word_last) begin
                        frame_count_d = frame_count_q + 32'd1;
                        // An eof already consumed means nothing is left to drain.
                        state_d = any_eof ? S_IDLE : S_DRAIN;
                    end else begin
                        state_d = S_BODY;
                    end
                end
            end
            default: begin
                if (~bus.rxff_empty & any_eof) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_count_q <= 32'd0;
            drop_count_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_d;
`ifdef RX_FRAME_READER_CRC_STRIP_EN
        wc_q    <= wc_d;
        lanes_q <= lanes_d;
`endif
    end
endmodule

// File: tb/tb_rx_frame_reader.sv
// Self-checking bench for rx_frame_reader: frame table plus hand sequences, scoreboard on the word stream.
module tb_rx_frame_reader;
    localparam int LEN_W = 14;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  lanes;
        logic        serr;
    } exp_t;

    typedef struct {
        int len;
        int early_w;
        int early_lane;
        bit toggle;
        int exp_pops;
        int exp_out_strip;
        int exp_out_full;
        int exp_serr_strip;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sync_err;
    logic [31:0] frame_count;
    logic [31:0] drop_count;

    rx_frame_reader_if #(.LEN_W(LEN_W)) bus ();

    rx_frame_reader #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .sync_err    (sync_err),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    logic [35:0]      ff_mem [0:4095];
    logic [LEN_W-1:0] rq_mem [0:63];
    int ff_wr = 0;
    int ff_rd = 0;
    int rq_wr = 0;
    int rq_rd = 0;
    logic flush = 1'b0;

    assign bus.rxff_empty = (ff_rd == ff_wr);
    assign bus.rxff_dout  = ff_mem[ff_rd[11:0]];
    assign bus.rfq_empty  = (rq_rd == rq_wr);
    assign bus.rfq_dout   = rq_mem[rq_rd[5:0]];

    always @(posedge clk) begin
        if (flush) begin
            ff_rd <= ff_wr;
            rq_rd <= rq_wr;
        end else begin
            if (bus.rxff_re) ff_rd <= ff_rd + 1;
            if (bus.rfq_re)  rq_rd <= rq_rd + 1;
        end
    end

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int n_rfq_re = 0;
    int n_rxff_re = 0;
    int n_serr = 0;
    int n_out = 0;
    bit toggle_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic [31:0] mask;
        @(negedge clk);
        if (bus.rfq_re) n_rfq_re++;
        if (sync_err) n_serr++;
        if (bus.rxff_re) begin
            n_rxff_re++;
            chk("rxff_re_when_empty", 32'(bus.rxff_empty), 0);
        end
        if (bus.rx_valid) begin
            chk("rxff_re_vs_ready", 32'(bus.rxff_re), 32'(bus.rx_ready));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: actual=%08h expected=none", bus.rx_data);
            end else begin
                e = exp_q[0];
                mask = 32'hFFFF_FFFF;
                if (e.last) begin
                    case (e.lanes)
                        2'd1:    mask = 32'hFF00_0000;
                        2'd2:    mask = 32'hFFFF_0000;
                        2'd3:    mask = 32'hFFFF_FF00;
                        default: mask = 32'hFFFF_FFFF;
                    endcase
                end
                chk("rx_data", bus.rx_data & mask, e.data & mask);
                chk("rx_last", 32'(bus.rx_last), 32'(e.last));
                if (e.last) chk("rx_lanes", 32'(bus.rx_lanes), 32'(e.lanes));
                chk("sync_err", 32'(sync_err), 32'(e.serr & bus.rx_ready));
                if (bus.rx_ready) begin
                    e = exp_q.pop_front();
                    n_out++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (toggle_rdy) bus.rx_ready = ~bus.rx_ready;
    endtask

    // Builds the FIFO image of one frame (2 length-field bytes, payload, 4 CRC bytes)
    // and queues the words the consumer should see.
    task automatic push_frame(input int len, input int early_w, input int early_lane);
        byte unsigned b[$];
        int n, nw, total, wc, nout, lanes, idx;
        bit early;
        logic [35:0] w;
        logic [7:0] bt;
        exp_t e;
        n = (len == 0) ? 20 : len + 6;
        if (early_w > 0) n = 4 * (early_w - 1) + early_lane + 1;
        for (int i = 0; i < n; i++) b.push_back((i < 2) ? 8'hEE : 8'((i * 7 + len) & 255));
        nw = (n + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                idx = 4 * wi + k;
                if (idx < n) w[34 - 9 * k -: 8] = b[idx];
                if (idx == n - 1) w[35 - 9 * k] = 1'b1;
            end
            ff_mem[ff_wr[11:0]] = w;
            ff_wr++;
        end
        if (len != 0) begin
            total = len + 2;
            wc = (total + 3) / 4;
`ifdef RX_FRAME_READER_CRC_STRIP_EN
            early = (nw < wc);
            nout  = early ? nw : wc;
            lanes = early ? (n - 4 * (nw - 1)) % 4 : total % 4;
`else
            early = 1'b0;
            nout  = nw;
            lanes = (n - 4 * (nw - 1)) % 4;
`endif
            for (int i = 0; i < nout; i++) begin
                for (int k = 0; k < 4; k++) begin
                    idx = 4 * i + k;
                    bt = (idx < n) ? b[idx] : 8'h00;
                    e.data[31 - 8 * k -: 8] = bt;
                end
                if (i == 0) e.data[31:16] = 16'(len);
                e.last  = (i == nout - 1);
                e.lanes = 2'(lanes);
                e.serr  = e.last & early;
                exp_q.push_back(e);
            end
        end
        rq_mem[rq_wr[5:0]] = LEN_W'(len);
        rq_wr++;
    endtask

    task automatic run_until_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ff_rd != ff_wr || rq_rd != rq_wr) && t < 600) begin
            cycle();
            t++;
        end
        if (t >= 600) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: actual=%0d cycles expected=<600", name, t);
        end
        repeat (3) cycle();
    endtask

    initial begin
        vec_t vecs[9];
        int p_rfq, p_ff, p_serr, p_out;
        int exp_fc, exp_dc, exp_out, exp_serr;

        vecs[0] = '{60,  0, 0, 1'b0, 17, 16, 17, 0};
        vecs[1] = '{0,   0, 0, 1'b0,  5,  0,  0, 0};
        vecs[2] = '{64,  0, 0, 1'b1, 18, 17, 18, 0};
        vecs[3] = '{100, 5, 3, 1'b0,  5,  5,  5, 1};
        vecs[4] = '{1,   0, 0, 1'b0,  2,  1,  2, 0};
        vecs[5] = '{2,   0, 0, 1'b1,  2,  1,  2, 0};
        vecs[6] = '{3,   0, 0, 1'b0,  3,  2,  3, 0};
        vecs[7] = '{50,  1, 1, 1'b0,  1,  1,  1, 1};
        vecs[8] = '{6,   0, 0, 1'b1,  3,  2,  3, 0};

        reset = 1'b1;
        enable = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (3) cycle();
        chk("reset_rfq_re",      32'(bus.rfq_re), 0);
        chk("reset_rxff_re",     32'(bus.rxff_re), 0);
        chk("reset_rx_valid",    32'(bus.rx_valid), 0);
        chk("reset_rx_last",     32'(bus.rx_last), 0);
        chk("reset_rx_lanes",    32'(bus.rx_lanes), 0);
        chk("reset_sync_err",    32'(sync_err), 0);
        chk("reset_frame_count", frame_count, 0);
        chk("reset_drop_count",  drop_count, 0);

        reset = 1'b0;
        enable = 1'b1;
        exp_fc = 0;
        exp_dc = 0;
        foreach (vecs[i]) begin
            p_rfq = n_rfq_re; p_ff = n_rxff_re; p_serr = n_serr; p_out = n_out;
            bus.rx_ready = 1'b1;
            toggle_rdy = vecs[i].toggle;
            push_frame(vecs[i].len, vecs[i].early_w, vecs[i].early_lane);
            run_until_idle("vec");
            toggle_rdy = 1'b0;
            bus.rx_ready = 1'b1;
            if (vecs[i].len == 0) exp_dc++; else exp_fc++;
`ifdef RX_FRAME_READER_CRC_STRIP_EN
            exp_out  = vecs[i].exp_out_strip;
            exp_serr = vecs[i].exp_serr_strip;
`else
            exp_out  = vecs[i].exp_out_full;
            exp_serr = 0;
`endif
            chk("rfq_re_pulses",   n_rfq_re - p_rfq, 1);
            chk("rxff_pops",       n_rxff_re - p_ff, vecs[i].exp_pops);
            chk("words_out",       n_out - p_out, exp_out);
            chk("sync_err_pulses", n_serr - p_serr, exp_serr);
            chk("frame_count",     frame_count, exp_fc);
            chk("drop_count",      drop_count, exp_dc);
        end

        // Back-to-back descriptors: good frame followed by a dropped one.
        p_rfq = n_rfq_re; p_ff = n_rxff_re; p_out = n_out;
        push_frame(10, 0, 0);
        push_frame(0, 0, 0);
        run_until_idle("b2b");
        exp_fc++;
        exp_dc++;
`ifdef RX_FRAME_READER_CRC_STRIP_EN
        exp_out = 3;
`else
        exp_out = 4;
`endif
        chk("b2b_rfq_re_pulses", n_rfq_re - p_rfq, 2);
        chk("b2b_rxff_pops",     n_rxff_re - p_ff, 9);
        chk("b2b_words_out",     n_out - p_out, exp_out);
        chk("b2b_frame_count",   frame_count, exp_fc);
        chk("b2b_drop_count",    drop_count, exp_dc);

        // Reset in the middle of a frame, then hold enable low with a descriptor pending.
        push_frame(100, 0, 0);
        repeat (6) cycle();
        rq_mem[rq_wr[5:0]] = LEN_W'(40);
        rq_wr++;
        enable = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();
        exp_q.delete();
        chk("midrst_rx_valid",    32'(bus.rx_valid), 0);
        chk("midrst_rfq_re",      32'(bus.rfq_re), 0);
        chk("midrst_rxff_re",     32'(bus.rxff_re), 0);
        chk("midrst_rx_last",     32'(bus.rx_last), 0);
        chk("midrst_rx_lanes",    32'(bus.rx_lanes), 0);
        chk("midrst_sync_err",    32'(sync_err), 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_drop_count",  drop_count, 0);
        reset = 1'b0;
        p_rfq = n_rfq_re; p_ff = n_rxff_re; p_out = n_out;
        repeat (10) cycle();
        chk("disabled_rfq_re_pulses", n_rfq_re - p_rfq, 0);
        chk("disabled_rxff_pops",     n_rxff_re - p_ff, 0);
        chk("disabled_words_out",     n_out - p_out, 0);
        chk("disabled_rfq_pending",   32'(bus.rfq_empty), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
